// File: rtl/cmd_scheduler.sv
// Command scheduler: buffers host command words in a FIFO and dispatches them one at a time on a
// shared cmd bus, waiting for masked slave acks (with timeout) and an idle gap between commands.
module cmd_scheduler #(
    parameter int            DEPTH      = 8,
    parameter int            NS         = 3,
    parameter logic [NS-1:0] ACK_MASK   = NS'(1),
    parameter int            TIMEOUT    = 1024,
    parameter int            GAP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_rqst,
    input  logic [5:0]             in_addr,
    input  logic [31:0]            in_data,
    output logic                   in_full,
    output logic [$clog2(DEPTH):0] in_level,
    output logic [5:0]             cmd_addr,
    output logic [31:0]            cmd_data,
    output logic                   cmd_rqst,
    input  logic [NS-1:0]          slv_ack,
    output logic                   busy,
    input  logic                   clr_status,
    output logic                   ovf_err,
    output logic                   tmo_err
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = $clog2(TIMEOUT + GAP_CYCLES + 1);
    localparam logic [AW:0]     LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t        state, state_nxt, post_cmd;
    logic [5:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [CW-1:0] cnt;
    logic [NS-1:0] ack_seen, ack_all;
    logic          full, pop, push, drop, acks_done, tmo_hit;

    assign full      = (level == LVL_FULL);
    assign pop       = (state == IDLE) && (level != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push      = in_rqst && (!full || pop);
    assign drop      = in_rqst && full && !pop;
    assign ack_all   = ack_seen | (slv_ack & ACK_MASK);
    assign acks_done = (ack_all == ACK_MASK);
    assign tmo_hit   = (state == WAIT) && !acks_done && (cnt == TMO_LAST);
    assign post_cmd  = (GAP_CYCLES > 0) ? GAP : IDLE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = ISSUE;
            ISSUE:   state_nxt = (ACK_MASK == '0) ? post_cmd : WAIT;
            WAIT:    if (acks_done || tmo_hit) state_nxt = post_cmd;
            GAP:     if (cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= in_addr;
            mem_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            cnt      <= '0;
            ack_seen <= '0;
            cmd_addr <= '0;
            cmd_data <= '0;
            ovf_err  <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                cmd_addr <= mem_addr[rd_ptr];
                cmd_data <= mem_data[rd_ptr];
            end
            // One counter serves both WAIT timeout and GAP length; it restarts on every state change.
            if (state_nxt != state)
                cnt <= '0;
            else if (state == WAIT || state == GAP)
                cnt <= cnt + CW'(1);
            if (state == ISSUE)
                ack_seen <= '0;
            else if (state == WAIT)
                ack_seen <= ack_all;
            if (drop)
                ovf_err <= 1'b1;
            else if (clr_status)
                ovf_err <= 1'b0;
            if (tmo_hit)
                tmo_err <= 1'b1;
            else if (clr_status)
                tmo_err <= 1'b0;
        end
    end

    assign cmd_rqst = (state == ISSUE);
    assign in_full  = full;
    assign in_level = level;
    assign busy     = (state != IDLE) || (level != '0);

endmodule

// File: tb/tb_cmd_scheduler.sv
// Bench for cmd_scheduler: directed stimulus pushes expected dispatches (addr, data, cycle) into
// per-DUT queues; a negedge monitor pops and compares on every cmd_rqst.
module tb_cmd_scheduler;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_rqst = 1'b0, b_rqst = 1'b0;
    logic [5:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic [2:0]  slv_ack = '0;
    logic        clr_status = 1'b0;

    logic        a_full, a_cmd_rqst, a_busy, a_ovf, a_tmo;
    logic [3:0]  a_level;
    logic [5:0]  a_cmd_addr;
    logic [31:0] a_cmd_data;
    logic        b_full, b_cmd_rqst, b_busy, b_ovf, b_tmo;
    logic [3:0]  b_level;
    logic [5:0]  b_cmd_addr;
    logic [31:0] b_cmd_data;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    bit   auto_ack = 1'b0;
    int   rsp_cnt = 0;

    // A: waits for slaves 0 and 2; B: fire-and-forget with no gap.
    cmd_scheduler #(.DEPTH(8), .NS(3), .ACK_MASK(3'b101), .TIMEOUT(1024), .GAP_CYCLES(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_rqst(a_rqst), .in_addr(a_addr), .in_data(a_data),
        .in_full(a_full), .in_level(a_level), .cmd_addr(a_cmd_addr), .cmd_data(a_cmd_data),
        .cmd_rqst(a_cmd_rqst), .slv_ack(slv_ack), .busy(a_busy), .clr_status(clr_status),
        .ovf_err(a_ovf), .tmo_err(a_tmo)
    );

    cmd_scheduler #(.DEPTH(8), .NS(3), .ACK_MASK(3'b000), .TIMEOUT(1024), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .in_rqst(b_rqst), .in_addr(b_addr), .in_data(b_data),
        .in_full(b_full), .in_level(b_level), .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data),
        .cmd_rqst(b_cmd_rqst), .slv_ack(slv_ack), .busy(b_busy), .clr_status(clr_status),
        .ovf_err(b_ovf), .tmo_err(b_tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) step();
    endtask

    task automatic pulse_a(logic [5:0] ad, logic [31:0] d, int exp_cyc);
        exp_t e;
        if (exp_cyc >= 0) begin
            e.addr = ad; e.data = d; e.cyc = exp_cyc;
            sb_a.push_back(e);
        end
        a_rqst = 1'b1; a_addr = ad; a_data = d;
        step();
        a_rqst = 1'b0;
    endtask

    task automatic pulse_b(logic [5:0] ad, logic [31:0] d, int exp_cyc);
        exp_t e;
        e.addr = ad; e.data = d; e.cyc = exp_cyc;
        sb_b.push_back(e);
        b_rqst = 1'b1; b_addr = ad; b_data = d;
        step();
        b_rqst = 1'b0;
    endtask

    task automatic drain(int maxc);
        int n = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0 || a_busy || b_busy) && n < maxc) begin
            step();
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending after %0d cycles, expected 0",
                     sb_a.size(), sb_b.size(), maxc);
        end
    endtask

    // Slave model for A: acks slaves 0 and 2 together three cycles after each cmd_rqst.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack) begin
                slv_ack = '0;
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) slv_ack = 3'b101;
                end
                if (a_cmd_rqst) rsp_cnt = 3;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_cmd_rqst) begin
                if (sb_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_rqst: got addr 0x%0h at cycle %0d, expected none",
                             a_cmd_addr, cyc);
                end else begin
                    e = sb_a.pop_front();
                    chk("a_cmd_addr", 32'(a_cmd_addr), 32'(e.addr));
                    chk("a_cmd_data", a_cmd_data, e.data);
                    chk("a_rqst_cycle", cyc, e.cyc);
                end
            end
            if (b_cmd_rqst) begin
                if (sb_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_rqst: got addr 0x%0h at cycle %0d, expected none",
                             b_cmd_addr, cyc);
                end else begin
                    e = sb_b.pop_front();
                    chk("b_cmd_addr", 32'(b_cmd_addr), 32'(e.addr));
                    chk("b_cmd_data", b_cmd_data, e.data);
                    chk("b_rqst_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m;
        // Reset state
        repeat (3) step();
        chk("rst_a_level", 32'(a_level), 0);
        chk("rst_a_full", 32'(a_full), 0);
        chk("rst_a_rqst", 32'(a_cmd_rqst), 0);
        chk("rst_a_addr", 32'(a_cmd_addr), 0);
        chk("rst_a_data", a_cmd_data, 0);
        chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_a_ovf", 32'(a_ovf), 0);
        chk("rst_a_tmo", 32'(a_tmo), 0);
        chk("rst_b_busy", 32'(b_busy), 0);
        rst = 1'b0;
        repeat (2) step();

        // 1: single fire-and-forget command, then a back-to-back burst at one per 2 cycles
        n = cyc;
        pulse_b(6'h09, 32'h1234_5678, n + 2);
        wait_until(n + 6);
        chk("t1_hold_addr", 32'(b_cmd_addr), 32'h09);
        chk("t1_hold_data", b_cmd_data, 32'h1234_5678);
        chk("t1_rqst_low", 32'(b_cmd_rqst), 0);
        chk("t1_idle", 32'(b_busy), 0);
        n = cyc;
        pulse_b(6'h11, 32'hB000_0011, n + 2);
        pulse_b(6'h12, 32'hB000_0012, n + 4);
        pulse_b(6'h13, 32'hB000_0013, n + 6);
        drain(50);
        chk("t1_tail_addr", 32'(b_cmd_addr), 32'h13);

        // 2: eight back-to-back commands, ack 3 cycles after each -> 9-cycle spacing
        auto_ack = 1'b1;
        n = cyc;
        for (int k = 0; k < 8; k++)
            pulse_a(6'(16 + k), 32'hC0DE_0000 + 32'(k), n + 2 + 9 * k);
        chk("t2_level", 32'(a_level), 7);
        chk("t2_full", 32'(a_full), 0);
        drain(200);
        chk("t2_ovf", 32'(a_ovf), 0);
        chk("t2_tmo", 32'(a_tmo), 0);
        chk("t2_hold_addr", 32'(a_cmd_addr), 32'h17);
        chk("t2_hold_data", a_cmd_data, 32'hC0DE_0007);

        // 5: needs ack[0] and ack[2]; ISSUE-cycle acks and ack[1] are noise
        auto_ack = 1'b0;
        slv_ack = '0;
        step();
        n = cyc;
        pulse_a(6'h05, 32'h5555_0005, n + 2);
        pulse_a(6'h06, 32'h5555_0006, n + 15);
        slv_ack = 3'b101; step();
        slv_ack = 3'b000; step();
        slv_ack = 3'b001; step();
        slv_ack = 3'b010; step();
        slv_ack = 3'b000;
        wait_until(n + 8);
        chk("t5_still_waiting", 32'(a_busy), 1);
        chk("t5_level", 32'(a_level), 1);
        wait_until(n + 9);
        slv_ack = 3'b100; step();
        slv_ack = 3'b000;
        auto_ack = 1'b1;
        drain(100);
        chk("t5_tmo", 32'(a_tmo), 0);

        // 3/4: a stuck command, then 9 pulses fill the FIFO and drop one; timeout releases the queue
        auto_ack = 1'b0;
        slv_ack = '0;
        step();
        m = cyc;
        pulse_a(6'h20, 32'hDEAD_0020, m + 2);
        wait_until(m + 10);
        for (int k = 0; k < 9; k++) begin
            chk("t3_level", 32'(a_level), 32'(k));
            chk("t3_full", 32'(a_full), (k == 8) ? 32'd1 : 32'd0);
            chk("t3_ovf_pre", 32'(a_ovf), 0);
            pulse_a(6'(40 + k), 32'h3000_0000 + 32'(k), (k < 8) ? m + 1032 + 9 * k : -1);
        end
        chk("t3_ovf", 32'(a_ovf), 1);
        chk("t3_level_full", 32'(a_level), 8);
        chk("t3_full_held", 32'(a_full), 1);
        a_rqst = 1'b1; clr_status = 1'b1;
        step();
        a_rqst = 1'b0; clr_status = 1'b0;
        chk("t3_ovf_wins_clr", 32'(a_ovf), 1);
        chk("t3_level_unch", 32'(a_level), 8);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("t3_ovf_clr", 32'(a_ovf), 0);
        wait_until(m + 1026);
        chk("t4_tmo_before", 32'(a_tmo), 0);
        step();
        chk("t4_tmo_set", 32'(a_tmo), 1);
        auto_ack = 1'b1;
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("t4_tmo_clr", 32'(a_tmo), 0);
        drain(300);
        chk("t4_tmo_quiet", 32'(a_tmo), 0);

        // 6: reset during WAIT with 4 queued flushes everything; a new command works afterwards
        auto_ack = 1'b0;
        slv_ack = '0;
        step();
        n = cyc;
        pulse_a(6'h30, 32'h6000_0030, n + 2);
        for (int k = 1; k < 5; k++)
            pulse_a(6'(48 + k), 32'h6000_0030 + 32'(k), -1);
        chk("t6_level_pre", 32'(a_level), 4);
        wait_until(n + 8);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_level", 32'(a_level), 0);
        chk("t6_rst_busy", 32'(a_busy), 0);
        chk("t6_rst_rqst", 32'(a_cmd_rqst), 0);
        chk("t6_rst_addr", 32'(a_cmd_addr), 0);
        chk("t6_rst_data", a_cmd_data, 0);
        step();
        rst = 1'b0;
        repeat (6) step();
        chk("t6_post_busy", 32'(a_busy), 0);
        auto_ack = 1'b1;
        n = cyc;
        pulse_a(6'h3F, 32'hFEED_003F, n + 2);
        drain(50);
        chk("t6_new_addr", 32'(a_cmd_addr), 32'h3F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
